// File: rtl/sb_alloc_ctrl.sv
// Store-buffer allocation/retirement controller: hands out in-order SB IDs, tracks
// committed/speculative/free regions of the circular buffer, sequences drains and flush reclaim.
module sb_alloc_ctrl #(
    parameter int SB_DEPTH     = 16,
    parameter int SB_IDX_WIDTH = $clog2(SB_DEPTH),
    parameter int CNT_WIDTH    = SB_IDX_WIDTH + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [3:0]                alloc_req_i,
    input  logic                      dispatch_fire_i,
    output logic                      alloc_ready_o,
    output logic [4*SB_IDX_WIDTH-1:0] alloc_id_o,
    input  logic [2:0]                commit_cnt_i,
    output logic                      drain_valid_o,
    output logic [SB_IDX_WIDTH-1:0]   drain_id_o,
    input  logic                      drain_ready_i,
    input  logic                      flush_i,
    output logic [CNT_WIDTH-1:0]      count_o,
    output logic [CNT_WIDTH-1:0]      committed_cnt_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      err_o
);

    localparam int PTR_W = SB_IDX_WIDTH + 1;

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     commit_q, commit_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic                 err_q, err_d;

    logic [CNT_WIDTH-1:0] occ_s, cmt_s, spec_s, free_s;
    logic [CNT_WIDTH-1:0] req_cnt_s, alloc_n_s, avail_s, commit_in_s;
    logic [PTR_W-1:0]     tail_alloc_s;
    logic [2:0]           req_pop_s;
    logic [2:0]           pre_s;
    logic                 alloc_fire_s, drain_fire_s, over_commit_s;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Region sizes: pointer differences wrap naturally thanks to the extra wrap bit.
    always_comb begin
        occ_s       = tail_q - head_q;
        cmt_s       = commit_q - head_q;
        spec_s      = tail_q - commit_q;
        free_s      = CNT_WIDTH'(SB_DEPTH) - occ_s;
        req_pop_s   = popcnt4(alloc_req_i);
        req_cnt_s   = {{(CNT_WIDTH-3){1'b0}}, req_pop_s};
        commit_in_s = {{(CNT_WIDTH-3){1'b0}}, commit_cnt_i};
    end

    // Per-slot IDs: each requesting slot takes the next ID after the requesting slots below it.
    always_comb begin
        alloc_id_o = '0;
        pre_s      = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (alloc_req_i[i]) begin
                alloc_id_o[i*SB_IDX_WIDTH +: SB_IDX_WIDTH] = tail_q[SB_IDX_WIDTH-1:0] + SB_IDX_WIDTH'(pre_s);
                pre_s = pre_s + 3'd1;
            end else begin
                alloc_id_o[i*SB_IDX_WIDTH +: SB_IDX_WIDTH] = '0;
            end
        end
    end

    // Readiness uses only current occupancy, so it never loops back through dispatch_fire_i.
    assign alloc_ready_o = (free_s >= req_cnt_s);

    // Next-state pointers: commit may cover same-cycle allocations; flush rewinds tail to commit.
    always_comb begin
        alloc_fire_s  = dispatch_fire_i && !flush_i && alloc_ready_o;
        drain_fire_s  = (cmt_s != '0) && drain_ready_i;
        alloc_n_s     = alloc_fire_s ? req_cnt_s : '0;
        avail_s       = spec_s + alloc_n_s;
        over_commit_s = (commit_in_s > avail_s);
        tail_alloc_s  = tail_q + alloc_n_s;
        if (over_commit_s) begin
            commit_d = tail_alloc_s;
        end else begin
            commit_d = commit_q + commit_in_s;
        end
        if (flush_i) begin
            tail_d = commit_d;
        end else begin
            tail_d = tail_alloc_s;
        end
        if (drain_fire_s) begin
            head_d = head_q + PTR_W'(1'b1);
        end else begin
            head_d = head_q;
        end
        err_d = err_q | over_commit_s;
    end

    // State registers with asynchronous reset to an empty buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            err_q    <= err_d;
        end
    end

    assign count_o         = occ_s;
    assign committed_cnt_o = cmt_s;
    assign full_o          = (occ_s == CNT_WIDTH'(SB_DEPTH));
    assign empty_o         = (occ_s == '0);
    assign drain_valid_o   = (cmt_s != '0);
    assign drain_id_o      = head_q[SB_IDX_WIDTH-1:0];
    assign err_o           = err_q;

endmodule

// File: doc/sb_alloc_ctrl.md
Name: sb_alloc_ctrl

Overview:
Allocation and retirement controller for the 16-entry store buffer. Hands out up to four in-order SB IDs per cycle to the rename stage and tracks three regions of the circular buffer: committed-awaiting-drain, speculative, and free. Sequences head-of-buffer drains to memory and reclaims speculative entries on pipeline flush. Sits between rename (alloc), ROB commit (commit count) and the store-buffer/LSU write port (drain).

Parameters:
SB_DEPTH, 16, number of store-buffer entries; power of two, at least 4
SB_IDX_WIDTH, $clog2(SB_DEPTH), entry index width
CNT_WIDTH, SB_IDX_WIDTH+1, occupancy counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
alloc_req_i  in  4  per-slot store request from rename (store mask)
dispatch_fire_i  in  1  rename group accepted this cycle (rename_ready and ROB accept)
alloc_ready_o  out  1  free entries >= popcount(alloc_req_i); combinational
alloc_id_o  out  4xSB_IDX_WIDTH  ID per requesting slot; combinational
commit_cnt_i  in  3  stores committed by ROB this cycle, 0..4
drain_valid_o  out  1  head entry is committed and may be written to memory
drain_id_o  out  SB_IDX_WIDTH  head entry index
drain_ready_i  in  1  memory accepted head entry
flush_i  in  1  pipeline flush; discard all speculative entries
count_o  out  CNT_WIDTH  total occupied entries
committed_cnt_o  out  CNT_WIDTH  committed, undrained entries
full_o  out  1  count_o == SB_DEPTH
empty_o  out  1  count_o == 0
err_o  out  1  sticky protocol-error flag

Behaviour:
- State: head_q, commit_q, tail_q pointers of SB_IDX_WIDTH+1 bits (MSB is the wrap bit). Occupied = tail-head, committed = commit-head, speculative = tail-commit, all modulo 2^(SB_IDX_WIDTH+1).
- Reset: all pointers 0, err_o 0. Outputs after reset: count_o 0, committed_cnt_o 0, empty_o 1, full_o 0, drain_valid_o 0, drain_id_o 0, alloc_ready_o 1 whenever free >= popcount, which covers any request after reset.
- ID assignment (combinational): for slot i with alloc_req_i[i]=1, alloc_id_o[i] = (tail_q + number of set req bits in slots 0..i-1) mod SB_DEPTH. Non-requesting slots output 0. Wrap from 15 to 0 is contiguous.
- alloc_ready_o = (SB_DEPTH - count) >= popcount(alloc_req_i). It does not depend on dispatch_fire_i, so no combinational loop is formed with rename.
- Allocate: when dispatch_fire_i && !flush_i && alloc_ready_o, tail advances by popcount(alloc_req_i) at the clock edge.
- Commit: commit_q advances by commit_cnt_i at the edge. If commit_cnt_i exceeds speculative + same-cycle allocations, commit_q clamps to tail_q and err_o sets.
- Drain: drain_valid_o = committed > 0. drain_id_o = head_q[SB_IDX_WIDTH-1:0]. On drain_valid_o && drain_ready_i, head advances by 1. At most one drain per cycle. drain_valid_o never drops without an acceptance, except at reset.
- drain_ready_i while drain_valid_o is 0 is ignored. No error is raised.
- Flush: commits in the same cycle apply first, then tail_q <- updated commit_q. Same-cycle allocation is dropped. Committed entries survive and keep draining. A drain in the same cycle still retires.
- Simultaneous alloc, commit and drain in one cycle (no flush): all three pointers update independently. Free space freed by a drain is visible to allocation only from the next cycle.
- Full: count_o==16 gives alloc_ready_o=0 for any nonzero request. A zero request is always ready.
- Reset asserted mid-operation: all state is discarded immediately (asynchronous). Memory-side writes in flight are the LSU's responsibility.

Test Plan:
1. Reset, then alloc_req_i=4'b1011 with dispatch_fire_i=1 -> ids {0,1,-,2} (slot3=2); next cycle count_o=3, drain_valid_o=0.
2. From tail=14 (ROB-driven commits and drains to empty first), alloc_req_i=4'b1111 with fire -> ids 14,15,0,1; tail wraps, wrap bit toggles, count_o=4.
3. 14 entries occupied, alloc_req_i=4'b0111 -> alloc_ready_o=0 and tail unchanged even with fire; alloc_req_i=4'b0011 -> ready=1, then full_o=1.
4. Allocate 6, commit_cnt_i=2, drain_ready_i=0 -> drain_valid_o=1, drain_id_o=0 held stable; raise drain_ready_i for 2 cycles -> ids 0 then 1 retire, then drain_valid_o=0, count_o=4.
5. 8 allocated, 3 committed; flush_i with commit_cnt_i=1 and alloc_req_i=4'b0001 fire in the same cycle -> next cycle count_o=4, committed_cnt_o=4, next alloc id=4.
6. commit_cnt_i=2 with 1 speculative entry -> err_o=1 (sticky), commit_q==tail_q; assert rst_ni=0 mid-drain -> all outputs return to reset values without a clock edge.
